// File: rtl/io_ram_sync.sv
// Clocked MC14500B data RAM: word memory with mapped output latches,
// input pins and a post-reset clear. Option: IO_RAM_SYNC_INPUT_EN.
module io_ram_sync #(
    parameter int WORD     = 1,
    parameter int SIZE_LOG = 8,
    parameter int OUTPUT   = 8,
    parameter int INPUT    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                write,
    input  logic                                read,
    input  logic [SIZE_LOG-1:0]                 address,
    input  logic [WORD-1:0]                     data_in,
    output logic [WORD-1:0]                     data_out,
    output logic                                data_valid,
    output logic                                busy,
    input  logic [(INPUT > 0 ? INPUT : 1)-1:0]  input_pins,
    output logic [(OUTPUT > 0 ? OUTPUT : 1)-1:0] output_pins
);

    localparam int SIZE = 2 ** SIZE_LOG;
    localparam int IN_W = (INPUT > 0) ? INPUT : 1;
    localparam logic [SIZE_LOG:0] IN_LO = (SIZE_LOG + 1)'(OUTPUT);
    localparam logic [SIZE_LOG:0] IN_HI = (SIZE_LOG + 1)'(OUTPUT + INPUT);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [SIZE_LOG-1:0]  r_clr_addr;
    logic [WORD-1:0]      r_mem [SIZE];
    logic [IN_W-1:0]      w_pins;

    logic                 w_clear;
    logic                 w_ready;
    logic                 w_clr_last;
    logic                 w_in_win;
    logic                 w_mem_we;
    logic                 w_pin;
    logic [SIZE_LOG:0]    w_addr_x;
    logic [SIZE_LOG-1:0]  w_mem_addr;
    logic [SIZE_LOG-1:0]  w_pin_idx;
    logic [WORD-1:0]      w_mem_wd;
    logic [WORD-1:0]      w_rd_word;

    assign w_clear    = (r_state == S_CLEAR);
    assign w_ready    = (r_state == S_READY);
    assign w_clr_last = (r_clr_addr == SIZE_LOG'(SIZE - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) r_clr_addr <= r_clr_addr + SIZE_LOG'(1);
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_CLEAR: if (w_clr_last) w_next = S_READY;
            S_READY: w_next = S_READY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = w_clear;
    end

`ifdef IO_RAM_SYNC_INPUT_EN
    logic [IN_W-1:0] r_sync1;
    logic [IN_W-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= input_pins;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pins = r_sync2;
`else
    assign w_pins = input_pins;
`endif

    assign w_addr_x  = {1'b0, address};
    assign w_in_win  = (w_addr_x >= IN_LO) && (w_addr_x < IN_HI);
    assign w_pin_idx = address - SIZE_LOG'(OUTPUT);

    always_comb begin
        w_pin = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (w_pin_idx == SIZE_LOG'(i)) w_pin = w_pins[i];
        end
    end

    // Writes into the input window are dropped; the clear owns the port.
    assign w_mem_we   = rst_n && (w_clear || (w_ready && write && !w_in_win));
    assign w_mem_addr = w_clear ? r_clr_addr : address;
    assign w_mem_wd   = w_clear ? '0 : data_in;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wd;
    end

    always_comb begin
        if (w_in_win)   w_rd_word = WORD'(w_pin);
        else if (write) w_rd_word = data_in;
        else            w_rd_word = r_mem[address];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (w_ready && read) begin
            data_out   <= w_rd_word;
            data_valid <= 1'b1;
        end else begin
            data_valid <= 1'b0;
        end
    end

    generate
        if (OUTPUT > 0) begin : g_out
            logic [OUTPUT-1:0] r_out;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out <= '0;
                end else begin
                    for (int i = 0; i < OUTPUT; i++) begin
                        if (w_clear && r_clr_addr == SIZE_LOG'(i))
                            r_out[i] <= 1'b0;
                        else if (w_ready && write && address == SIZE_LOG'(i))
                            r_out[i] <= data_in[0];
                    end
                end
            end

            assign output_pins = r_out;
        end else begin : g_no_out
            assign output_pins = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_io_ram_sync.sv
// Randomized bench for io_ram_sync against a behavioural memory model.
// Covers clear timing, mapped I/O, write-first collisions, mid-clear reset.
module tb_io_ram_sync;

    localparam int WORD     = 1;
    localparam int SIZE_LOG = 8;
    localparam int SIZE     = 2 ** SIZE_LOG;
    localparam int OUTPUT   = 8;
    localparam int INPUT    = 8;

    logic                clk;
    logic                rst_n;
    logic                wr;
    logic                rd;
    logic [SIZE_LOG-1:0] addr;
    logic [WORD-1:0]     din;
    logic [WORD-1:0]     dout;
    logic                dv;
    logic                busy;
    logic [INPUT-1:0]    pins;
    logic [OUTPUT-1:0]   opins;

    io_ram_sync #(
        .WORD     (WORD),
        .SIZE_LOG (SIZE_LOG),
        .OUTPUT   (OUTPUT),
        .INPUT    (INPUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write       (wr),
        .read        (rd),
        .address     (addr),
        .data_in     (din),
        .data_out    (dout),
        .data_valid  (dv),
        .busy        (busy),
        .input_pins  (pins),
        .output_pins (opins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model
    logic [WORD-1:0]   m_mem [SIZE];
    logic [OUTPUT-1:0] m_opins;
    logic [WORD-1:0]   m_dout;
    logic              m_dv;
    int                m_left;
    logic [INPUT-1:0]  m_s1;
    logic [INPUT-1:0]  m_s2;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void model_edge();
        logic [INPUT-1:0] seen;
        int a;
        bit inwin;
        if (!rst_n) begin
            m_left  = SIZE;
            m_dv    = 1'b0;
            m_dout  = '0;
            m_opins = '0;
            m_s1    = '0;
            m_s2    = '0;
            return;
        end
`ifdef IO_RAM_SYNC_INPUT_EN
        seen = m_s2;
`else
        seen = pins;
`endif
        m_s2 = m_s1;
        m_s1 = pins;
        if (m_left > 0) begin
            a = SIZE - m_left;
            m_mem[a] = '0;
            if (a < OUTPUT) m_opins[a] = 1'b0;
            m_left--;
            m_dv = 1'b0;
            return;
        end
        a = int'(addr);
        inwin = (a >= OUTPUT) && (a < OUTPUT + INPUT);
        if (rd) begin
            m_dv = 1'b1;
            if (inwin)   m_dout = WORD'(seen[a-OUTPUT]);
            else if (wr) m_dout = din;
            else         m_dout = m_mem[a];
        end else begin
            m_dv = 1'b0;
        end
        if (wr && !inwin) begin
            m_mem[a] = din;
            if (a < OUTPUT) m_opins[a] = din[0];
        end
    endfunction

    task automatic step(input logic r_n, input logic w, input logic r,
                        input logic [SIZE_LOG-1:0] a, input logic [WORD-1:0] d);
        rst_n = r_n;
        wr    = w;
        rd    = r;
        addr  = a;
        din   = d;
        @(posedge clk);
        model_edge();
        #1;
        check("busy", 32'(busy), 32'(m_left > 0));
        check("valid", 32'(dv), 32'(m_dv));
        check("data_out", 32'(dout), 32'(m_dout));
        check("output_pins", 32'(opins), 32'(m_opins));
    endtask

    task automatic rand_step(input int rst_odds);
        logic [SIZE_LOG-1:0] a;
        if ($urandom_range(0, 1) == 0) a = SIZE_LOG'($urandom_range(0, 31));
        else                          a = SIZE_LOG'($urandom);
        if ($urandom_range(0, 3) == 0) pins = INPUT'($urandom);
        step((rst_odds > 0 && $urandom_range(0, rst_odds) == 0) ? 1'b0 : 1'b1,
             1'($urandom), 1'($urandom), a, WORD'($urandom));
    endtask

    int cnt;

    initial begin
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        addr  = '0;
        din   = '0;
        pins  = '0;

        step(0, 0, 0, 8'h00, 0);
        step(0, 1, 1, 8'h20, 1);

        // Accesses during the clear are ignored
        for (int i = 0; i < SIZE; i++)
            step(1, 1, i[0], 8'h10, 1);

        step(1, 1, 0, 8'h20, 1);
        step(1, 0, 1, 8'h20, 0);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 1, 8'h10, 0);
        step(1, 1, 0, 8'h03, 1);
        step(1, 1, 0, 8'h03, 0);
        pins = 8'h05;
        step(1, 0, 1, 8'h08, 0);
        step(1, 0, 1, 8'h09, 0);
        step(1, 1, 0, 8'h09, 1);
        step(1, 0, 1, 8'h09, 0);
        step(1, 1, 1, 8'h40, 1);
        step(1, 1, 1, 8'h08, 0);
        step(1, 0, 0, 8'h00, 0);

        for (int i = 0; i < 2000; i++) rand_step(0);

        // Preload, then reset in the middle of a clear
        for (int i = 0; i < 64; i++)
            step(1, 1, 0, SIZE_LOG'($urandom), 1);
        step(1, 1, 0, 8'h7F, 1);
        step(1, 1, 0, 8'hFF, 1);
        step(1, 1, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 8'h00, 0);
        cnt = 0;
        step(0, 0, 0, 8'h00, 0);
        while (busy && cnt < 400) begin
            cnt++;
            step(1, 1, 1, 8'h7F, 1);
        end
        check("busy_len", 32'(cnt), 32'(SIZE));
        step(1, 0, 1, 8'h00, 0);
        step(1, 0, 1, 8'h7F, 0);
        step(1, 0, 1, 8'hFF, 0);
        step(1, 0, 0, 8'h00, 0);

        for (int i = 0; i < 3000; i++) rand_step(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
